// File: rtl/pc_fetch_unit.sv
// PC register and fetch sequencer: IDLE -> FETCH -> ISSUED loop with redirect, stall and misalign halt.
// Optional delivered-instruction counter enabled by defining PC_FETCH_COUNT_EN.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_target_i,
  input  logic [31:0] seq_pc_i,
  output logic [31:0] pc_o,
  output logic        imem_req_o,
  input  logic        imem_ack_i,
  input  logic [31:0] inst_i,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic        misalign_o,
  output logic [31:0] fetch_count_o
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUED, HALT} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] inst_reg, inst_next;
  logic        misalign_reg, misalign_next;
  logic        target_ok;

  assign target_ok = (redirect_target_i[1:0] == 2'b00);

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    inst_next     = inst_reg;
    misalign_next = misalign_reg;
    case (state_reg)
      IDLE: begin
        state_next = FETCH;
        if (redirect_i) begin
          if (target_ok) begin
            pc_next = redirect_target_i;
          end else begin
            misalign_next = 1'b1;
            state_next    = HALT;
          end
        end
      end
      FETCH: begin
        // A redirect wins over a same-cycle ack; the acked word is dropped.
        if (redirect_i) begin
          if (target_ok) begin
            pc_next    = redirect_target_i;
            state_next = IDLE;
          end else begin
            misalign_next = 1'b1;
            state_next    = HALT;
          end
        end else if (imem_ack_i) begin
          inst_next  = inst_i;
          state_next = ISSUED;
        end
      end
      ISSUED: begin
        if (redirect_i) begin
          if (target_ok) begin
            pc_next    = redirect_target_i;
            state_next = IDLE;
          end else begin
            misalign_next = 1'b1;
            state_next    = HALT;
          end
        end else if (!stall_i) begin
          pc_next    = seq_pc_i;
          state_next = FETCH;
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      pc_reg       <= RESET_VECTOR;
      inst_reg     <= 32'h0000_0000;
      misalign_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      inst_reg     <= inst_next;
      misalign_reg <= misalign_next;
    end
  end

  assign pc_o         = pc_reg;
  assign inst_o       = inst_reg;
  assign misalign_o   = misalign_reg;
  assign imem_req_o   = (state_reg == FETCH);
  assign inst_valid_o = (state_reg == ISSUED);

`ifdef PC_FETCH_COUNT_EN
  logic        accept;
  logic [31:0] count_reg;

  assign accept = (state_reg == FETCH) && imem_ack_i && !redirect_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= 32'h0000_0000;
    end else if (accept) begin
      count_reg <= count_reg + 32'd1;
    end
  end

  assign fetch_count_o = count_reg;
`else
  assign fetch_count_o = 32'h0000_0000;
`endif

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Program-counter register and fetch sequencer for the single-cycle CPU. It drives pc_o into the external 32-bit adder, which computes pc+4. It consumes that adder's sum as seq_pc_i, selects the next PC (sequential, redirect or hold), and runs the request/acknowledge handshake to instruction memory. Decoded-stage logic receives a registered instruction with a valid flag.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
stall_i  input  1  downstream not ready; hold current instruction and PC
redirect_i  input  1  branch/jump taken; single-cycle pulse
redirect_target_i  input  32  redirect destination address
seq_pc_i  input  32  sequential next PC from external adder (pc_o + 4)
pc_o  output  32  current PC; also the instruction-memory address
imem_req_o  output  1  fetch request to instruction memory
imem_ack_i  input  1  instruction memory has data for pc_o this cycle
inst_i  input  32  instruction word from memory, valid with imem_ack_i
inst_o  output  32  registered instruction
inst_valid_o  output  1  inst_o holds the instruction at pc_o
misalign_o  output  1  sticky flag: misaligned redirect target seen
fetch_count_o  output  32  delivered-instruction counter (see Optional Feature)

Behaviour:
- Reset (rst=1 at an edge): pc_o=RESET_VECTOR, state=IDLE, imem_req_o=0, inst_o=0, inst_valid_o=0, misalign_o=0, fetch_count_o=0.
- Reset overrides everything, including mid-fetch and HALT.
- States: IDLE, FETCH, ISSUED, HALT. imem_req_o=1 only in FETCH; inst_valid_o=1 only in ISSUED.
- IDLE: one-cycle bubble, then FETCH. No PC change unless redirect_i (see below).
- FETCH:
  - imem_req_o=1; pc_o is stable for the whole request.
  - On imem_ack_i: inst_o<=inst_i and go to ISSUED.
  - Without ack, stay in FETCH; no timeout.
- ISSUED:
  - redirect_i has priority over stall_i.
  - On redirect_i: pc_o<=redirect_target_i, inst_valid_o<=0, go to IDLE.
  - Else if !stall_i: pc_o<=seq_pc_i, go to FETCH.
  - Else hold pc_o, inst_o and inst_valid_o unchanged.
- Redirect during FETCH: pc_o<=redirect_target_i and go to IDLE. Any imem_ack_i in the same cycle is discarded (inst_o unchanged, not counted). The IDLE cycle deasserts imem_req_o so memory sees a clean new request.
- Redirect in IDLE: pc_o<=redirect_target_i; still proceeds to FETCH next cycle.
- Misaligned target (redirect_target_i[1:0]!=0):
  - PC is not updated; misalign_o<=1 (sticky); state goes to HALT.
  - HALT: imem_req_o=0, inst_valid_o=0; all inputs ignored until rst.
- stall_i is ignored outside ISSUED.
- Latency:
  - redirect_i to imem_req_o on the new PC: 2 cycles (through IDLE).
  - Sequential advance from ISSUED to the next request: 1 cycle.
  - imem_ack_i to inst_valid_o: 1 cycle.
- Wrap-around: seq_pc_i is taken verbatim. 32'hFFFF_FFFC advancing to 32'h0000_0000 is legal. The unit never adds internally.
- seq_pc_i is sampled only on the ISSUED to FETCH transition.

Optional Feature:
Macro: PC_FETCH_COUNT_EN.
- Defined: fetch_count_o increments by 1 on every accepted (non-discarded) imem_ack_i, wrapping at 2^32; reset to 0.
- Undefined: counter logic is absent and fetch_count_o is tied to 0.
- The port exists in both builds.

Test Plan:
1. Reset release, RESET_VECTOR=0x0000_1000, memory acks 1 cycle after each request, stall_i=0, seq_pc_i=pc_o+4:
   - imem_req_o first rises 1 cycle after reset release.
   - pc_o steps 0x1000, 0x1004, 0x1008.
   - inst_valid_o pulses once per instruction, each pulse holding the matching inst_i.
2. stall_i=1 for 3 cycles while in ISSUED at pc 0x1004:
   - pc_o, inst_o and inst_valid_o=1 all hold.
   - After stall_i drops, pc_o=0x1008 the next cycle with imem_req_o=1.
3. redirect_i with target 0x2000 in the same cycle as imem_ack_i while in FETCH at 0x1008:
   - The acked instruction is dropped (inst_valid_o stays 0; count unchanged with PC_FETCH_COUNT_EN).
   - pc_o=0x2000; imem_req_o is 0 for one cycle, then 1.
4. redirect_i and stall_i together in ISSUED, target 0x3000: pc_o=0x3000 and inst_valid_o=0 next cycle (redirect wins).
5. Misaligned target 0x2002:
   - misalign_o=1; pc_o is unchanged; no further imem_req_o even if redirect_i toggles.
   - rst for one cycle clears misalign_o and restarts fetching at RESET_VECTOR.
6. Wrap: pc_o=0xFFFF_FFFC with seq_pc_i=0 → next fetch at pc_o=0x0000_0000. With PC_FETCH_COUNT_EN, fetch_count_o equals the number of accepted acks.
